stile_mac: RTL and testbench



---
 rtl/stile_pkg.sv | 22 ++
 rtl/stile_sdp_ram.sv | 38 +++
 rtl/stile_mac.sv | 193 +++++++++++++++++++
 tb/tb_stile_mac.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stile_pkg.sv
// Shared types and constants for the SuperTile MAC engine.
package stile_pkg;

    localparam int unsigned STILE_P_BIT = 48;

    // Cycles from the last address issue to the result strobe.
    localparam int unsigned PIPE_LAT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        ADD_ZERO  = 2'd0,
        ADD_SUMIN = 2'd1,
        ADD_CASIN = 2'd2,
        ADD_RSVD  = 2'd3
    } add_sel_t;

endpackage

// File: rtl/stile_sdp_ram.sv
// Simple dual-port RAM, read-first; RD_LAT=0 gives an async read, RD_LAT=2 a
// registered array read followed by an output register.
module stile_sdp_ram #(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 10,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    if (RD_LAT == 2) begin : g_sync
        logic [DW-1:0] rd1_q;
        logic [DW-1:0] rd2_q;

        always_ff @(posedge clk_i) begin
            rd1_q <= mem_q[raddr_i];
            rd2_q <= rd1_q;
        end

        assign rdata_o = rd2_q;
    end else begin : g_async
        assign rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/stile_mac.sv
// SuperTile MAC: weight/activation buffers feeding one signed MAC pipeline
// with start/busy/done control and a selectable initial addend.
module stile_mac
    import stile_pkg::*;
#(
    parameter int unsigned W_BIT       = 16,
    parameter int unsigned ACT_BIT     = 16,
    parameter int unsigned WADDR_BIT   = 10,
    parameter int unsigned ACTADDR_BIT = 6,
    parameter int unsigned P_BIT       = STILE_P_BIT
) (
    input  logic                   clk_h,
    input  logic                   rst,
    input  logic                   w_wr_en,
    input  logic [WADDR_BIT-1:0]   w_wr_addr,
    input  logic [W_BIT-1:0]       w_wr_data,
    input  logic                   act_wr_en,
    input  logic [ACTADDR_BIT-1:0] act_wr_addr,
    input  logic [ACT_BIT-1:0]     act_wr_data,
    input  logic                   start,
    input  logic [ACTADDR_BIT:0]   cfg_len,
    input  logic [WADDR_BIT-1:0]   cfg_w_base,
    input  logic [1:0]             cfg_add_sel,
    input  logic [P_BIT-1:0]       p_sumin,
    input  logic [P_BIT-1:0]       p_casin,
    output logic                   busy,
    output logic                   done,
    output logic                   p_valid,
    output logic [P_BIT-1:0]       p_out,
    output logic [P_BIT-1:0]       p_casout
);

    localparam int unsigned PROD_BIT = W_BIT + ACT_BIT;
    localparam logic [ACTADDR_BIT:0] LEN_MAX = {1'b1, {ACTADDR_BIT{1'b0}}};
    localparam logic [ACTADDR_BIT:0] LEN_ONE = (ACTADDR_BIT+1)'(1);
    localparam logic [1:0] DRAIN_INIT = 2'(PIPE_LAT - 2);

    state_t state_q, state_d;

    logic [ACTADDR_BIT:0]   len_q;
    logic [ACTADDR_BIT:0]   k_q;
    logic [WADDR_BIT-1:0]   w_addr_q;
    logic [P_BIT-1:0]       addend_q;
    logic [1:0]             drain_q;
    logic                   accept;
    logic                   issue;
    logic                   last_term;

    logic [W_BIT-1:0]       w_rd_data;
    logic [ACT_BIT-1:0]     act_rd_data;

    logic                   s1_v_q, s1_first_q, s1_last_q;
    logic                   s2_v_q, s2_first_q, s2_last_q;
    logic                   m_v_q, m_first_q, m_last_q;
    logic [ACT_BIT-1:0]     act1_q, act2_q;
    logic signed [PROD_BIT-1:0] w_ext, a_ext;
    logic [PROD_BIT-1:0]    m_q;
    logic [P_BIT-1:0]       m_sext;
    logic [P_BIT-1:0]       acc_q, acc_d;
    logic [P_BIT-1:0]       p_out_q;
    logic                   p_valid_q;

    assign accept    = start && (state_q == IDLE) && (cfg_len != '0);
    assign issue     = (state_q == RUN);
    assign last_term = (k_q == len_q - LEN_ONE);

    stile_sdp_ram #(
        .DW     (W_BIT),
        .AW     (WADDR_BIT),
        .RD_LAT (2)
    ) u_wbuf (
        .clk_i   (clk_h),
        .we_i    (w_wr_en),
        .waddr_i (w_wr_addr),
        .wdata_i (w_wr_data),
        .raddr_i (w_addr_q),
        .rdata_o (w_rd_data)
    );

    stile_sdp_ram #(
        .DW     (ACT_BIT),
        .AW     (ACTADDR_BIT),
        .RD_LAT (0)
    ) u_abuf (
        .clk_i   (clk_h),
        .we_i    (act_wr_en),
        .waddr_i (act_wr_addr),
        .wdata_i (act_wr_data),
        .raddr_i (k_q[ACTADDR_BIT-1:0]),
        .rdata_o (act_rd_data)
    );

    always_ff @(posedge clk_h) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_term) state_d = DRAIN;
            DRAIN:   if (drain_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = p_valid_q;
        p_valid = p_valid_q;
    end

    // Run configuration and address generation.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            len_q    <= '0;
            k_q      <= '0;
            w_addr_q <= '0;
            addend_q <= '0;
            drain_q  <= '0;
        end else if (accept) begin
            len_q    <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            k_q      <= '0;
            w_addr_q <= cfg_w_base;
            drain_q  <= DRAIN_INIT;
            unique case (add_sel_t'(cfg_add_sel))
                ADD_SUMIN: addend_q <= p_sumin;
                ADD_CASIN: addend_q <= p_casin;
                default:   addend_q <= '0;
            endcase
        end else if (state_q == RUN) begin
            k_q      <= k_q + LEN_ONE;
            w_addr_q <= w_addr_q + WADDR_BIT'(1);
        end else if (state_q == DRAIN) begin
            drain_q  <= drain_q - 2'd1;
        end
    end

    assign w_ext  = PROD_BIT'($signed(w_rd_data));
    assign a_ext  = PROD_BIT'($signed(act2_q));
    assign m_sext = {{(P_BIT-PROD_BIT){m_q[PROD_BIT-1]}}, m_q};
    assign acc_d  = (m_first_q ? addend_q : acc_q) + m_sext;

    // Term flags ride alongside the data so the accumulator needs no counters.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            m_v_q      <= 1'b0;
            m_first_q  <= 1'b0;
            m_last_q   <= 1'b0;
            act1_q     <= '0;
            act2_q     <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            p_out_q    <= '0;
            p_valid_q  <= 1'b0;
        end else begin
            s1_v_q     <= issue;
            s1_first_q <= (k_q == '0);
            s1_last_q  <= last_term;
            act1_q     <= act_rd_data;
            s2_v_q     <= s1_v_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            act2_q     <= act1_q;
            m_v_q      <= s2_v_q;
            m_first_q  <= s2_first_q;
            m_last_q   <= s2_last_q;
            m_q        <= w_ext * a_ext;
            p_valid_q  <= 1'b0;
            if (m_v_q) begin
                acc_q <= acc_d;
                if (m_last_q) begin
                    p_out_q   <= acc_d;
                    p_valid_q <= 1'b1;
                end
            end
        end
    end

    assign p_out    = p_out_q;
    assign p_casout = p_out_q;

endmodule

// File: tb/tb_stile_mac.sv
// Randomised and directed self-checking bench for stile_mac against a
// dot-product reference model.
module tb_stile_mac;

    logic        clk_h = 1'b0;
    logic        rst = 1'b1;
    logic        w_wr_en = 1'b0;
    logic [9:0]  w_wr_addr = '0;
    logic [15:0] w_wr_data = '0;
    logic        act_wr_en = 1'b0;
    logic [5:0]  act_wr_addr = '0;
    logic [15:0] act_wr_data = '0;
    logic        start = 1'b0;
    logic [6:0]  cfg_len = '0;
    logic [9:0]  cfg_w_base = '0;
    logic [1:0]  cfg_add_sel = '0;
    logic [47:0] p_sumin = '0;
    logic [47:0] p_casin = '0;
    logic        busy, done, p_valid;
    logic [47:0] p_out, p_casout;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic signed [15:0] wm [1024];
    logic signed [15:0] am [64];

    stile_mac #(
        .W_BIT       (16),
        .ACT_BIT     (16),
        .WADDR_BIT   (10),
        .ACTADDR_BIT (6),
        .P_BIT       (48)
    ) dut (
        .clk_h       (clk_h),
        .rst         (rst),
        .w_wr_en     (w_wr_en),
        .w_wr_addr   (w_wr_addr),
        .w_wr_data   (w_wr_data),
        .act_wr_en   (act_wr_en),
        .act_wr_addr (act_wr_addr),
        .act_wr_data (act_wr_data),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_w_base  (cfg_w_base),
        .cfg_add_sel (cfg_add_sel),
        .p_sumin     (p_sumin),
        .p_casin     (p_casin),
        .busy        (busy),
        .done        (done),
        .p_valid     (p_valid),
        .p_out       (p_out),
        .p_casout    (p_casout)
    );

    always #5 clk_h = ~clk_h;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    function automatic logic [47:0] r48();
        return {$urandom, $urandom};
    endfunction

    // Dot product of the clamped run length plus the chosen addend, mod 2^48.
    function automatic logic [47:0] model(input int len, input int base, input logic [1:0] sel,
                                          input logic [47:0] sumin, input logic [47:0] casin);
        logic [47:0] acc;
        longint      prod;
        int          eff;
        eff = (len > 64) ? 64 : len;
        acc = (sel == 2'd1) ? sumin : (sel == 2'd2) ? casin : 48'd0;
        for (int k = 0; k < eff; k++) begin
            prod = longint'(wm[(base + k) % 1024]) * longint'(am[k]);
            acc  = acc + 48'(prod);
        end
        return acc;
    endfunction

    task automatic wr(input logic we, input logic [9:0] wa, input logic [15:0] wd,
                      input logic ae, input logic [5:0] aa, input logic [15:0] ad);
        w_wr_en = we; w_wr_addr = wa; w_wr_data = wd;
        act_wr_en = ae; act_wr_addr = aa; act_wr_data = ad;
        tick();
        w_wr_en = 1'b0;
        act_wr_en = 1'b0;
        if (we) wm[wa] = wd;
        if (ae) am[aa] = ad;
    endtask

    // Drives start for one edge; leaves the bench in the cycle after acceptance.
    task automatic do_start(input logic [6:0] len, input logic [9:0] base, input logic [1:0] sel,
                            input logic [47:0] sumin, input logic [47:0] casin,
                            output logic [47:0] exp_v);
        exp_v = model(int'(len), int'(base), sel, sumin, casin);
        start = 1'b1; cfg_len = len; cfg_w_base = base; cfg_add_sel = sel;
        p_sumin = sumin; p_casin = casin;
        tick();
        start = 1'b0;
        p_sumin = r48();
        p_casin = r48();
        cfg_len = 7'($urandom);
        cfg_w_base = 10'($urandom);
    endtask

    // Waits for p_valid, starting the count at cycle 'cyc0' after acceptance.
    task automatic wait_res(input int cyc0, input int exp_lat, input logic [47:0] exp_v,
                            input string tag);
        int cyc = cyc0;
        while (p_valid !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, " p_out"}, 64'(p_out), 64'(exp_v));
        chk({tag, " p_casout"}, 64'(p_casout), 64'(exp_v));
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " busy end"}, 64'(busy), 64'd0);
    endtask

    task automatic after_res(input logic [47:0] exp_v, input string tag);
        tick();
        chk({tag, " p_valid pulse"}, 64'(p_valid), 64'd0);
        chk({tag, " done pulse"}, 64'(done), 64'd0);
        chk({tag, " hold"}, 64'(p_out), 64'(exp_v));
    endtask

    initial begin
        logic [47:0] ev, ev2;
        int          pv_seen;
        int          len, len2;

        repeat (3) tick();
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst p_valid", 64'(p_valid), 64'd0);
        chk("rst p_out", 64'(p_out), 64'd0);
        chk("rst p_casout", 64'(p_casout), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) wr(1'b1, 10'(i), 16'(i + 5), 1'b1, 6'(i), 16'(i + 1));
        do_start(7'd4, 10'd0, 2'd0, r48(), r48(), ev);
        chk("dot busy", 64'(busy), 64'd1);
        wait_res(1, 8, 48'd70, "dot");
        after_res(48'd70, "dot");

        do_start(7'd4, 10'd0, 2'd1, 48'd1000, r48(), ev);
        wait_res(1, 8, 48'd1070, "sumin");
        after_res(48'd1070, "sumin");

        wr(1'b1, 10'd1023, 16'hFFFE, 1'b1, 6'd0, 16'd4);
        wr(1'b1, 10'd0, 16'd3, 1'b1, 6'd1, 16'd5);
        do_start(7'd2, 10'd1023, 2'd0, r48(), r48(), ev);
        wait_res(1, 6, 48'd7, "wrap");

        wr(1'b1, 10'd0, 16'h8000, 1'b1, 6'd0, 16'h8000);
        do_start(7'd1, 10'd0, 2'd2, r48(), 48'hFFFF_FFFF_FFFF, ev);
        wait_res(1, 5, 48'h0000_3FFF_FFFF, "extreme");

        do_start(7'd0, 10'd0, 2'd0, r48(), r48(), ev);
        pv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0 || p_valid !== 1'b0) pv_seen++;
            tick();
        end
        chk("len0 ignored", 64'(pv_seen), 64'd0);

        for (int i = 0; i < 1024; i++)
            wr(1'b1, 10'(i), 16'($urandom), (i < 64), 6'(i), 16'($urandom));

        do_start(7'd64, 10'($urandom), 2'd1, r48(), r48(), ev);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst p_out", 64'(p_out), 64'd0);
        pv_seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (p_valid === 1'b1 || done === 1'b1) pv_seen++;
            tick();
        end
        chk("midrst no pulse", 64'(pv_seen), 64'd0);
        do_start(7'd9, 10'd1020, 2'd2, r48(), r48(), ev);
        wait_res(1, 13, ev, "post rst");

        len  = 5;
        len2 = 3;
        do_start(7'(len), 10'd100, 2'd1, r48(), r48(), ev);
        start = 1'b1; cfg_len = 7'd1; cfg_add_sel = 2'd2; p_casin = r48();
        tick();
        start = 1'b0;
        tick();
        wait_res(3, len + 4, ev, "b2b first");
        do_start(7'(len2), 10'd7, 2'd2, r48(), r48(), ev2);
        wait_res(1, len2 + 4, ev2, "b2b second");
        after_res(ev2, "b2b second");

        for (int r = 0; r < 20; r++) begin
            logic [6:0] rl;
            repeat (3) wr(1'b1, 10'($urandom), 16'($urandom), 1'b1, 6'($urandom), 16'($urandom));
            rl = 7'($urandom_range(1, 80));
            do_start(rl, 10'($urandom), 2'($urandom), r48(), r48(), ev);
            len = (int'(rl) > 64) ? 64 : int'(rl);
            wait_res(1, len + 4, ev, "random");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
